// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: lead delay, divided SCLK with edge strobes, trail delay.
// Transfer parameters are captured at start so mid-transfer input changes are ignored.
module spi_clk_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_go,
  input  logic                 i_abort,
  input  logic                 i_last_clk,
  input  logic [DIV_WIDTH-1:0] i_divider,
  input  logic                 i_cpol,
  input  logic [7:0]           i_lead,
  input  logic [7:0]           i_trail,
  output logic                 o_clk_out,
  output logic                 o_pos_edge,
  output logic                 o_neg_edge,
  output logic                 o_ss_active,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {StIdle, StLead, StRun, StTrail} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_s_q, div_s_d;
  logic                 cpol_s_q, cpol_s_d;
  logic [7:0]           lead_s_q, lead_s_d;
  logic [7:0]           trail_s_q, trail_s_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]           dly_cnt_q, dly_cnt_d;
  logic                 clk_out_q, clk_out_d;
  logic                 pos_q, pos_d;
  logic                 neg_q, neg_d;
  logic                 ss_q, ss_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;

  assign tick = (div_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    div_s_d   = div_s_q;
    cpol_s_d  = cpol_s_q;
    lead_s_d  = lead_s_q;
    trail_s_d = trail_s_q;
    div_cnt_d = div_cnt_q;
    dly_cnt_d = dly_cnt_q;
    clk_out_d = clk_out_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        clk_out_d = i_cpol;
        if (i_go) begin
          div_s_d   = i_divider;
          cpol_s_d  = i_cpol;
          lead_s_d  = i_lead;
          trail_s_d = i_trail;
          div_cnt_d = i_divider;
          dly_cnt_d = 8'd1;
          state_d   = (i_lead != 8'd0) ? StLead : StRun;
        end
      end
      StLead: begin
        if (dly_cnt_q == lead_s_q) begin
          state_d   = StRun;
          div_cnt_d = div_s_q;
        end else begin
          dly_cnt_d = dly_cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (tick) begin
          div_cnt_d = div_s_q;
          if (!i_last_clk) begin
            clk_out_d = ~clk_out_q;
            pos_d     = ~clk_out_q;
            neg_d     = clk_out_q;
          end else begin
            // Final tick only returns the pin to idle if it is not already there.
            if (clk_out_q != cpol_s_q) begin
              clk_out_d = cpol_s_q;
              pos_d     = cpol_s_q;
              neg_d     = ~cpol_s_q;
            end
            dly_cnt_d = 8'd1;
            if (trail_s_q == 8'd0) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StTrail;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
      end
      StTrail: begin
        if (dly_cnt_q == trail_s_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (i_abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      clk_out_d = cpol_s_q;
      pos_d     = 1'b0;
      neg_d     = 1'b0;
      done_d    = 1'b0;
    end

    ss_d   = (state_d != StIdle);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      div_s_q   <= '0;
      cpol_s_q  <= 1'b0;
      lead_s_q  <= 8'd0;
      trail_s_q <= 8'd0;
      div_cnt_q <= '0;
      dly_cnt_q <= 8'd0;
      clk_out_q <= i_cpol;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      ss_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_s_q   <= div_s_d;
      cpol_s_q  <= cpol_s_d;
      lead_s_q  <= lead_s_d;
      trail_s_q <= trail_s_d;
      div_cnt_q <= div_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      clk_out_q <= clk_out_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_clk_out   = clk_out_q;
  assign o_pos_edge  = pos_q;
  assign o_neg_edge  = neg_q;
  assign o_ss_active = ss_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Randomized bench for spi_clk_gen; expected waveforms are computed per transfer from
// lead/divider/trail arithmetic and compared cycle by cycle.
module tb_spi_clk_gen;
  localparam int DW = 16;
  localparam int NX = 40;

  logic          clk = 1'b0;
  logic          rst, go, abort, last_clk, cpol;
  logic [DW-1:0] divider;
  logic [7:0]    lead, trail;
  logic          clk_out, pos_edge, neg_edge, ss_active, busy, done;
  logic [5:0]    outs;

  always #5 clk = ~clk;

  spi_clk_gen #(.DIV_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_go       (go),
    .i_abort    (abort),
    .i_last_clk (last_clk),
    .i_divider  (divider),
    .i_cpol     (cpol),
    .i_lead     (lead),
    .i_trail    (trail),
    .o_clk_out  (clk_out),
    .o_pos_edge (pos_edge),
    .o_neg_edge (neg_edge),
    .o_ss_active(ss_active),
    .o_busy     (busy),
    .o_done     (done)
  );

  assign outs = {clk_out, pos_edge, neg_edge, ss_active, busy, done};

  int n_vec = 0;
  int n_err = 0;
  // Transfer table: kill 0=none, 1=abort, 2=reset at cycle kill_at.
  int p_div[NX], p_cpol[NX], p_lead[NX], p_trail[NX], p_k[NX];
  int p_kill[NX], p_kill_at[NX], p_b2b[NX];
  logic idle_cpol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_start(input int i);
    go       = 1'b1;
    divider  = DW'(p_div[i]);
    cpol     = p_cpol[i][0];
    lead     = 8'(p_lead[i]);
    trail    = 8'(p_trail[i]);
    last_clk = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic end_xfer(input int i);
    last_clk = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    if (p_b2b[i] != 0) begin
      apply_start(i + 1);
    end else begin
      go        = 1'b0;
      cpol      = 1'($urandom_range(1, 0));
      idle_cpol = cpol;
    end
  endtask

  task automatic run_xfer(input int i);
    int half, d, t, n, eff, ss_len;
    logic lvl, e_clk, e_pos, e_neg, kill_cpol;
    half      = p_div[i] + 1;
    d         = p_lead[i] + p_k[i] * half + p_trail[i] + 1;
    t         = (p_k[i] - 1) + ((p_k[i] - 1) % 2);
    ss_len    = 0;
    kill_cpol = 1'b0;
    for (int c = 1; c <= d; c++) begin
      @(posedge clk);
      #1;
      if (p_kill[i] != 0 && c == p_kill_at[i] + 1) begin
        check((p_kill[i] == 1) ? "abort" : "midreset", 32'(outs), 32'({kill_cpol, 5'b0}));
        end_xfer(i);
        return;
      end
      n     = 0;
      e_pos = 1'b0;
      e_neg = 1'b0;
      for (int j = 1; j <= t; j++) begin
        eff = p_lead[i] + j * half + 1;
        if (eff <= c) n++;
        if (eff == c) begin
          lvl   = p_cpol[i][0] ^ j[0];
          e_pos = lvl;
          e_neg = ~lvl;
        end
      end
      e_clk = p_cpol[i][0] ^ n[0];
      check("cycle", 32'(outs),
            32'({e_clk, e_pos, e_neg, (c < d), (c < d), (c == d)}));
      if (ss_active) ss_len++;
      if (c == d) begin
        check("ss_len", 32'(ss_len), 32'(d - 1));
        end_xfer(i);
      end else begin
        go       = 1'($urandom_range(1, 0));
        last_clk = (c > p_lead[i] + (p_k[i] - 1) * half);
        divider  = DW'($urandom_range(9, 0));
        cpol     = 1'($urandom_range(1, 0));
        lead     = 8'($urandom_range(5, 0));
        trail    = 8'($urandom_range(5, 0));
        if (p_kill[i] != 0 && c == p_kill_at[i]) begin
          if (p_kill[i] == 1) begin
            abort     = 1'b1;
            kill_cpol = p_cpol[i][0];
          end else begin
            rst       = 1'b1;
            kill_cpol = cpol;
          end
        end
      end
    end
  endtask

  initial begin
    int d;
    // Directed rows first, then randomized ones.
    p_div[0] = 1; p_cpol[0] = 0; p_lead[0] = 2; p_trail[0] = 3; p_k[0] = 16;
    p_div[1] = 0; p_cpol[1] = 1; p_lead[1] = 0; p_trail[1] = 0; p_k[1] = 8;
    p_div[2] = 1; p_cpol[2] = 0; p_lead[2] = 1; p_trail[2] = 1; p_k[2] = 12;
    p_div[3] = 7; p_cpol[3] = 0; p_lead[3] = 0; p_trail[3] = 2; p_k[3] = 4;
    p_div[4] = 1; p_cpol[4] = 0; p_lead[4] = 1; p_trail[4] = 2; p_k[4] = 10;
    p_div[5] = 2; p_cpol[5] = 1; p_lead[5] = 0; p_trail[5] = 1; p_k[5] = 10;
    for (int i = 0; i < 6; i++) begin
      p_kill[i] = 0; p_kill_at[i] = 0; p_b2b[i] = 0;
    end
    p_b2b[2]  = 1;
    p_kill[4] = 1; p_kill_at[4] = 4;
    p_kill[5] = 2; p_kill_at[5] = 7; p_b2b[5] = 1;
    for (int i = 6; i < NX; i++) begin
      p_div[i]   = $urandom_range(3, 0);
      p_cpol[i]  = $urandom_range(1, 0);
      p_lead[i]  = $urandom_range(3, 0);
      p_trail[i] = $urandom_range(3, 0);
      p_k[i]     = $urandom_range(12, 1);
      p_b2b[i]   = $urandom_range(1, 0);
      d          = p_lead[i] + p_k[i] * (p_div[i] + 1) + p_trail[i] + 1;
      case ($urandom_range(9, 0))
        0, 1:    p_kill[i] = 1;
        2:       p_kill[i] = 2;
        default: p_kill[i] = 0;
      endcase
      p_kill_at[i] = $urandom_range(d - 1, 1);
    end
    p_b2b[NX-1] = 0;

    rst = 1'b1; go = 1'b0; abort = 1'b0; last_clk = 1'b0; cpol = 1'b1;
    divider = '0; lead = 8'd0; trail = 8'd0; idle_cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(outs), 32'(6'b100000));
    apply_start(0);
    for (int i = 0; i < NX; i++) begin
      run_xfer(i);
      if (p_b2b[i] == 0) begin
        @(posedge clk);
        #1;
        check("idle", 32'(outs), 32'({idle_cpol, 5'b0}));
        if (i + 1 < NX) apply_start(i + 1);
        else go = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_clk_gen.md
SPI_CLK_GEN -- requirements
Module: spi_clk_gen

Interface
REQ-001 SHALL provide parameter DIV_WIDTH, default 16, meaning width of the half-period divider.
REQ-002 SHALL provide port i_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port i_go  input  1  start request, sampled only in IDLE.
REQ-005 SHALL provide port i_abort  input  1  terminate transfer immediately.
REQ-006 SHALL provide port i_last_clk  input  1  final bit reached (from shift stage o_last).
REQ-007 SHALL provide port i_divider  input  DIV_WIDTH  half-period = i_divider+1 i_clk cycles.
REQ-008 SHALL provide port i_cpol  input  1  idle level of o_clk_out.
REQ-009 SHALL provide port i_lead  input  8  select-to-first-edge delay, in i_clk cycles.
REQ-010 SHALL provide port i_trail  input  8  last-edge-to-deselect delay, in i_clk cycles.
REQ-011 SHALL provide port o_clk_out  output  1  serial clock pin level.
REQ-012 SHALL provide port o_pos_edge  output  1  one-cycle strobe, o_clk_out 0->1.
REQ-013 SHALL provide port o_neg_edge  output  1  one-cycle strobe, o_clk_out 1->0.
REQ-014 SHALL provide port o_ss_active  output  1  high while a transfer owns the bus.
REQ-015 SHALL provide port o_busy  output  1  high whenever FSM is not IDLE.
REQ-016 SHALL provide port o_done  output  1  one-cycle strobe on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, LEAD, RUN, TRAIL; all outputs registered.
REQ-018 In IDLE with i_go=1, SHALL latch i_divider, i_cpol, i_lead, i_trail into shadow registers; shadows alone govern the transfer, so input changes mid-transfer have no effect.
REQ-019 IDLE -> LEAD if latched lead != 0, else IDLE -> RUN; LEAD SHALL last exactly lead cycles, then RUN.
REQ-020 On RUN entry SHALL load half-period counter with shadow divider; counter decrements each RUN cycle; at value 0 a tick occurs and the counter reloads in the same cycle.
REQ-021 Divider 0 SHALL produce a tick every RUN cycle (sclk period 2 cycles); counter arithmetic unsigned, no wrap past 0.
REQ-022 On tick with i_last_clk=0, o_clk_out SHALL toggle.
REQ-023 On tick with i_last_clk=1 and o_clk_out != idle level, o_clk_out SHALL toggle back to idle level and FSM SHALL go to TRAIL (IDLE if trail=0).
REQ-024 On tick with i_last_clk=1 and o_clk_out at idle level, SHALL NOT toggle; FSM goes to TRAIL (IDLE if trail=0).
REQ-025 o_pos_edge/o_neg_edge SHALL be high exactly in the cycle o_clk_out shows its new level after a rising/falling toggle, per pin level (independent of cpol); never both high.
REQ-026 TRAIL SHALL last exactly trail cycles, then IDLE; o_done SHALL pulse in the first IDLE cycle after normal completion.
REQ-027 o_ss_active and o_busy SHALL be high in LEAD, RUN, TRAIL; low in IDLE.
REQ-028 i_go outside IDLE SHALL be ignored; i_go in the o_done cycle SHALL start a new transfer.
REQ-029 i_abort in any non-IDLE state SHALL force IDLE next cycle, o_clk_out to shadow idle level, no edge strobe, no o_done; i_abort has priority over i_go and tick.
REQ-030 In IDLE, o_clk_out SHALL track i_cpol, with no edge strobe.

Reset
REQ-031 On i_rst=1 SHALL enter IDLE; o_clk_out=i_cpol; o_pos_edge, o_neg_edge, o_ss_active, o_busy, o_done=0; counter and shadows cleared; reset mid-transfer behaves identically, with no o_done.

Verification
REQ-032 divider=1, cpol=0, lead=2, trail=3, i_last_clk raised after 8th o_pos_edge -> sclk period 4 cycles, 8 pos and 8 neg strobes, o_ss_active high 37 consecutive cycles, o_done one pulse.
REQ-033 divider=0, cpol=1, lead=0, trail=0 -> o_clk_out idles 1, first strobe o_neg_edge 1 cycle after RUN entry, period 2 cycles, o_done immediately after last o_pos_edge.
REQ-034 i_divider changed 1->7 mid-RUN -> period stays 4 cycles until completion; next transfer uses 16-cycle period.
REQ-035 i_abort asserted during RUN with o_clk_out=1, cpol=0 -> next cycle o_clk_out=0, o_busy=0, no o_neg_edge, no o_done.
REQ-036 i_go held high continuously -> back-to-back transfers; second starts in o_done cycle; i_go pulses during RUN ignored.
REQ-037 i_rst pulsed mid-RUN -> next cycle all outputs at reset values; i_go afterwards starts cleanly.
